// File: rtl/maxpool_sa_pkg.sv
// Shared types and geometry constants for the 2x2/stride-2 max-pool writer
// that fills the 16-bank source buffer.
package maxpool_sa_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_e;

  localparam int CONV1_IN_W  = 28;
  localparam int CONV2_IN_W  = 20;
  localparam int CONV1_CH    = 6;
  localparam int CONV2_CH    = 16;
  localparam int CONV1_BURST = 196;
  localparam int CONV2_BURST = 100;

  localparam int CONV1_OUT_W = CONV1_IN_W / 2;
  localparam int CONV2_OUT_W = CONV2_IN_W / 2;
  localparam int CONV1_BASE  = 0;
  localparam int CONV2_BASE  = CONV1_BURST;

  localparam logic [1:0] NTH_CONV1 = 2'd0;
  localparam logic [1:0] NTH_CONV2 = 2'd1;

  // The line buffer only has to hold one pooled row of the widest layer.
  localparam int LINE_BUF_DEPTH = CONV1_OUT_W;

endpackage

// File: rtl/maxpool_line_buf.sv
// Holds the horizontal maxima of the even input row so the odd row can finish
// each 2x2 window; one write port, asynchronous read.
module maxpool_line_buf
  import maxpool_sa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = LINE_BUF_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_i && (int'(waddr_i) < DEPTH)) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool_sa_writer.sv
// 2x2/stride-2 max-pool over a channel-sequential pixel stream; each pooled
// value is written to bank = channel of the source buffer, last_o kicks the DMA.
module maxpool_sa_writer
  import maxpool_sa_pkg::*;
#(
  parameter int SRC_DEPTH  = 1024,
  parameter int SRC_WIDTH  = 16,
  parameter int DATA_WIDTH = 8,
  localparam int WORD_W    = $clog2(SRC_DEPTH),
  localparam int BANK_W    = $clog2(SRC_WIDTH),
  localparam int ADDR_W    = WORD_W + BANK_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            nth_conv_i,
  input  logic                  din_valid_i,
  output logic                  din_ready_o,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic                  bram_en_o,
  output logic                  bram_we_o,
  output logic [ADDR_W-1:0]     bram_addr_o,
  output logic [DATA_WIDTH-1:0] bram_din_o,
  output logic                  busy_o,
  output logic                  last_o
);

  function automatic logic [DATA_WIDTH-1:0] max_u(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    return (a >= b) ? a : b;
  endfunction

  state_e                state_q, state_d;
  logic [4:0]            in_w_q, in_w_d;
  logic [3:0]            out_w_q, out_w_d;
  logic [BANK_W-1:0]     ch_last_q, ch_last_d;
  logic [WORD_W-1:0]     base_q, base_d;
  logic [4:0]            col_q, col_d;
  logic [4:0]            row_q, row_d;
  logic [BANK_W-1:0]     ch_q, ch_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic                  en_q, en_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  last_q, last_d;

  logic                  lb_we;
  logic [DATA_WIDTH-1:0] lb_rdata;
  logic [DATA_WIDTH-1:0] h_max;
  logic [DATA_WIDTH-1:0] pool_max;
  logic [WORD_W-1:0]     word_idx;
  logic                  col_end, row_end, frame_end;

  maxpool_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (LINE_BUF_DEPTH)
  ) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (lb_we),
    .waddr_i (col_q[4:1]),
    .wdata_i (h_max),
    .raddr_i (col_q[4:1]),
    .rdata_o (lb_rdata)
  );

  assign h_max     = max_u(pair_q, din_i);
  assign pool_max  = max_u(h_max, lb_rdata);
  assign word_idx  = base_q + WORD_W'(row_q[4:1]) * WORD_W'(out_w_q) + WORD_W'(col_q[4:1]);
  assign col_end   = (col_q == in_w_q - 5'd1);
  assign row_end   = (row_q == in_w_q - 5'd1);
  assign frame_end = col_end && row_end && (ch_q == ch_last_q);

  always_comb begin
    state_d   = state_q;
    in_w_d    = in_w_q;
    out_w_d   = out_w_q;
    ch_last_d = ch_last_q;
    base_d    = base_q;
    col_d     = col_q;
    row_d     = row_q;
    ch_d      = ch_q;
    pair_d    = pair_q;
    en_d      = 1'b0;
    addr_d    = '0;
    din_d     = '0;
    last_d    = 1'b0;
    lb_we     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && (nth_conv_i == NTH_CONV1)) begin
          in_w_d    = 5'(CONV1_IN_W);
          out_w_d   = 4'(CONV1_OUT_W);
          ch_last_d = BANK_W'(CONV1_CH - 1);
          base_d    = WORD_W'(CONV1_BASE);
          col_d     = '0;
          row_d     = '0;
          ch_d      = '0;
          state_d   = S_RUN;
        end else if (start && (nth_conv_i == NTH_CONV2)) begin
          in_w_d    = 5'(CONV2_IN_W);
          out_w_d   = 4'(CONV2_OUT_W);
          ch_last_d = BANK_W'(CONV2_CH - 1);
          base_d    = WORD_W'(CONV2_BASE);
          col_d     = '0;
          row_d     = '0;
          ch_d      = '0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (din_valid_i) begin
          // Even column opens a horizontal pair; odd row closes the 2x2 window.
          if (!col_q[0]) begin
            pair_d = din_i;
          end else if (!row_q[0]) begin
            lb_we = 1'b1;
          end else begin
            en_d   = 1'b1;
            addr_d = {ch_q, word_idx};
            din_d  = pool_max;
          end

          if (col_end) begin
            col_d = '0;
            if (row_end) begin
              row_d = '0;
              ch_d  = ch_q + BANK_W'(1);
            end else begin
              row_d = row_q + 5'd1;
            end
          end else begin
            col_d = col_q + 5'd1;
          end

          if (frame_end) begin
            state_d = S_LAST;
          end
        end
      end

      S_LAST: begin
        last_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      in_w_q    <= '0;
      out_w_q   <= '0;
      ch_last_q <= '0;
      base_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      ch_q      <= '0;
      pair_q    <= '0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_w_q    <= in_w_d;
      out_w_q   <= out_w_d;
      ch_last_q <= ch_last_d;
      base_q    <= base_d;
      col_q     <= col_d;
      row_q     <= row_d;
      ch_q      <= ch_d;
      pair_q    <= pair_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      last_q    <= last_d;
    end
  end

  assign din_ready_o = (state_q == S_RUN);
  assign busy_o      = (state_q != S_IDLE);
  assign bram_en_o   = en_q;
  assign bram_we_o   = en_q;
  assign bram_addr_o = addr_q;
  assign bram_din_o  = din_q;
  assign last_o      = last_q;

endmodule

// File: tb/tb_maxpool_sa_writer.sv
// Scoreboard bench for maxpool_sa_writer: a whole-frame reference pooling model
// fills an expectation queue, a monitor checks every bus cycle against it.
module tb_maxpool_sa_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  nth_conv_i;
  logic        din_valid_i;
  logic        din_ready_o;
  logic [7:0]  din_i;
  logic        bram_en_o;
  logic        bram_we_o;
  logic [13:0] bram_addr_o;
  logic [7:0]  bram_din_o;
  logic        busy_o;
  logic        last_o;

  maxpool_sa_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .nth_conv_i  (nth_conv_i),
    .din_valid_i (din_valid_i),
    .din_ready_o (din_ready_o),
    .din_i       (din_i),
    .bram_en_o   (bram_en_o),
    .bram_we_o   (bram_we_o),
    .bram_addr_o (bram_addr_o),
    .bram_din_o  (bram_din_o),
    .busy_o      (busy_o),
    .last_o      (last_o)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          wr_cnt = 0;
  int          last_cnt = 0;
  logic        beat_wr = 1'b0;
  logic [7:0]  img [16][28][28];
  logic [7:0]  mem [16384];
  logic [13:0] exp_addr_q [$];
  logic [7:0]  exp_data_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_ready"}, din_ready_o, 0);
    chk({tag, "_en"},    bram_en_o, 0);
    chk({tag, "_we"},    bram_we_o, 0);
    chk({tag, "_addr"},  bram_addr_o, 0);
    chk({tag, "_din"},   bram_din_o, 0);
    chk({tag, "_last"},  last_o, 0);
  endtask

  // Monitor: every write must arrive one cycle after a window-closing beat and
  // match the head of the expectation queue; idle bus must be all zero.
  initial begin : monitor
    logic pending;
    pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 1'b0;
        continue;
      end
      chk("wr_timing", bram_en_o, pending);
      if (bram_en_o) begin
        wr_cnt++;
        chk("wr_we", bram_we_o, 1);
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_wr", bram_addr_o, 14'h3fff);
        end else begin
          logic [13:0] ea;
          logic [7:0]  ed;
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          chk("wr_addr", bram_addr_o, ea);
          chk("wr_data", bram_din_o, ed);
        end
        mem[bram_addr_o] = bram_din_o;
      end else begin
        chk("idle_bus", {bram_we_o, bram_addr_o, bram_din_o}, 0);
      end
      if (last_o) last_cnt++;
      pending = din_valid_i && din_ready_o && beat_wr;
    end
  end

  // mode 0: ramp pattern, 1: random, 2: random with fixed corner windows.
  task automatic run_frame(input int conv, input int mode, input int prob,
                           input int start_at, input int abort_at);
    int iw, ow, nch, base, idx, last0;
    iw   = conv ? 20 : 28;
    ow   = iw / 2;
    nch  = conv ? 16 : 6;
    base = conv ? 196 : 0;

    for (int c = 0; c < nch; c++)
      for (int r = 0; r < iw; r++)
        for (int x = 0; x < iw; x++)
          img[c][r][x] = (mode == 0) ? 8'((c * 7 + r * 28 + x) % 256) : 8'($urandom_range(255));
    if (mode == 2) begin
      img[0][0][0] = 8'h00; img[0][0][1] = 8'hFF;
      img[0][1][0] = 8'h80; img[0][1][1] = 8'h7F;
      img[0][0][2] = 8'h42; img[0][0][3] = 8'h42;
      img[0][1][2] = 8'h42; img[0][1][3] = 8'h42;
    end

    exp_addr_q.delete();
    exp_data_q.delete();
    for (int c = 0; c < nch; c++)
      for (int pr = 0; pr < ow; pr++)
        for (int pc = 0; pc < ow; pc++) begin
          int m;
          m = 0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (int'(img[c][2*pr+dr][2*pc+dc]) > m) m = int'(img[c][2*pr+dr][2*pc+dc]);
          exp_addr_q.push_back(14'((c << 10) | (base + pr * ow + pc)));
          exp_data_q.push_back(8'(m));
        end

    wr_cnt = 0;
    last0  = last_cnt;
    @(posedge clk); #1;
    nth_conv_i = 2'(conv);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    idx = 0;
    for (int c = 0; c < nch; c++)
      for (int r = 0; r < iw; r++)
        for (int x = 0; x < iw; x++) begin
          bit done;
          int tries;
          if (idx == abort_at) begin
            din_valid_i = 1'b0;
            beat_wr     = 1'b0;
            rst_n       = 1'b0;
            #1;
            chk_all_zero("abort");
            repeat (3) @(posedge clk);
            chk("abort_no_last", last_cnt - last0, 0);
            exp_addr_q.delete();
            exp_data_q.delete();
            #1 rst_n = 1'b1;
            return;
          end
          done  = 1'b0;
          tries = 0;
          while (!done) begin
            din_valid_i = (prob >= 100) ? 1'b1 : ($urandom_range(99) < prob);
            din_i       = img[c][r][x];
            beat_wr     = r[0] && x[0];
            start       = (idx == start_at);
            @(negedge clk);
            done = din_valid_i && din_ready_o;
            @(posedge clk); #1;
            tries++;
            if (tries > 500) begin
              $display("FAIL handshake_timeout: got no acceptance expected acceptance at beat %0d", idx);
              $fatal(1);
            end
          end
          idx++;
        end
    din_valid_i = 1'b0;
    beat_wr     = 1'b0;
    start       = 1'b0;

    @(negedge clk);
    chk("final_busy", busy_o, 1);
    chk("final_ready", din_ready_o, 0);
    chk("last_early", last_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("last_pulse", last_o, 1);
    chk("busy_done", busy_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("last_once", last_o, 0);
    chk("wr_count", wr_cnt, nch * ow * ow);
    chk("queue_drained", exp_addr_q.size(), 0);
    chk("last_count", last_cnt - last0, 1);
  endtask

  initial begin : stim
    int w0, l0;
    rst_n       = 1'b0;
    start       = 1'b0;
    nth_conv_i  = 2'd0;
    din_valid_i = 1'b0;
    din_i       = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    run_frame(0, 0, 100, -1, -1);
    chk("b0_w0_pattern", mem[14'd0], 29);
    chk("b5_w195_pattern", mem[{4'd5, 10'd195}], 50);

    run_frame(1, 1, 50, -1, -1);

    run_frame(0, 2, 100, 1000, -1);
    chk("unsigned_window", mem[14'd0], 8'hFF);
    chk("equal_window", mem[14'd1], 8'h42);

    w0 = wr_cnt;
    l0 = last_cnt;
    for (int n = 2; n < 4; n++) begin
      @(posedge clk); #1;
      nth_conv_i  = 2'(n);
      start       = 1'b1;
      din_valid_i = 1'b1;
      din_i       = 8'hA5;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
        @(negedge clk);
        chk("bad_conv_busy", busy_o, 0);
        chk("bad_conv_ready", din_ready_o, 0);
      end
    end
    din_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    chk("bad_conv_writes", wr_cnt - w0, 0);
    chk("bad_conv_last", last_cnt - l0, 0);

    run_frame(0, 0, 100, -1, (2 * 28 + 13) * 28);
    repeat (2) @(posedge clk);
    run_frame(0, 0, 100, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
